// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_pkg
// Brief    : Shared pipeline constants and the hazard scoreboard entry type.
// Revision : 1.0
// ============================================================================
package pipeline_pkg;

    localparam int         REG_W      = 3;
    localparam logic [4:0] NOP_OPCODE = 5'b00001;

    localparam int SLOT_EX   = 0;
    localparam int SLOT_MEM  = 1;
    localparam int SLOT_WB   = 2;
    localparam int NUM_SLOTS = 3;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dst;
    } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/hazard_stall_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_unit_if
// Brief    : Decode-stage operand/destination bus and stall controls.
// Revision : 1.0
// ============================================================================
interface hazard_stall_unit_if #(
    parameter int CNT_W = 16
);
    import pipeline_pkg::*;

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_rs_used;
    logic             id_rt_used;
    logic [REG_W-1:0] id_dst;
    logic             id_reg_write;
    logic             flush;
    logic             stall;
    logic             pc_en;
    logic             ifid_en;
    logic             flush_ifid;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_rs, id_rt, id_rs_used, id_rt_used, id_dst, id_reg_write, flush,
        input  stall, pc_en, ifid_en, flush_ifid, stall_count
    );

    modport slave (
        input  id_rs, id_rt, id_rs_used, id_rt_used, id_dst, id_reg_write, flush,
        output stall, pc_en, ifid_en, flush_ifid, stall_count
    );

endinterface
`default_nettype wire

// File: rtl/sb_slot.sv
`default_nettype none
// ============================================================================
// Module   : sb_slot
// Brief    : One scoreboard slot {valid, dst} with its source-operand matchers.
// Revision : 1.0
// ============================================================================
module sb_slot
    import pipeline_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  sb_entry_t        i_d,
    output sb_entry_t        o_q,
    input  logic [REG_W-1:0] i_rs,
    input  logic             i_rs_used,
    input  logic [REG_W-1:0] i_rt,
    input  logic             i_rt_used,
    output logic             o_hit_rs,
    output logic             o_hit_rt
);

    sb_entry_t r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q      = r_q;
    assign o_hit_rs = i_rs_used & r_q.valid & (r_q.dst == i_rs);
    assign o_hit_rt = i_rt_used & r_q.valid & (r_q.dst == i_rt);

endmodule
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_unit
// Brief    : Decode-stage RAW hazard detector, bubble/flush control and
//            saturating stall-cycle counter for the 5-stage pipeline.
// Revision : 1.0
// ============================================================================
module hazard_stall_unit
    import pipeline_pkg::*;
#(
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 16
)(
    input  logic                clk,
    input  logic                rst,
    hazard_stall_unit_if.slave  hz
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    sb_entry_t            w_slot_d [NUM_SLOTS];
    sb_entry_t            w_slot_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] w_hit_rs;
    logic [NUM_SLOTS-1:0] w_hit_rt;
    logic [NUM_SLOTS-1:0] w_checked;
    logic                 w_hazard;
    logic                 w_stall;
    logic [CNT_W-1:0]     r_stall_count;
    logic                 w_unused;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            sb_slot u_slot (
                .clk       (clk),
                .rst       (rst),
                .i_d       (w_slot_d[gi]),
                .o_q       (w_slot_q[gi]),
                .i_rs      (hz.id_rs),
                .i_rs_used (hz.id_rs_used),
                .i_rt      (hz.id_rt),
                .i_rt_used (hz.id_rt_used),
                .o_hit_rs  (w_hit_rs[gi]),
                .o_hit_rt  (w_hit_rt[gi])
            );

            // With a write-before-read register file the WB producer is already visible.
            if ((gi == SLOT_WB) && (WB_BYPASS != 0)) begin : g_bypassed
                assign w_checked[gi] = 1'b0;
            end else begin : g_checked
                assign w_checked[gi] = 1'b1;
            end
        end
    endgenerate

    assign w_hazard = |((w_hit_rs | w_hit_rt) & w_checked);
    assign w_stall  = w_hazard & ~hz.flush & ~rst;

    // A stall or a squash sends a bubble into EX; older entries always advance.
    always_comb begin
        w_slot_d[SLOT_EX].valid = hz.id_reg_write & ~(hz.flush | w_stall);
        w_slot_d[SLOT_EX].dst   = hz.id_dst;
        w_slot_d[SLOT_MEM]      = w_slot_q[SLOT_EX];
        w_slot_d[SLOT_WB]       = w_slot_q[SLOT_MEM];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != c_cnt_max)) begin
            r_stall_count <= r_stall_count + c_cnt_one;
        end
    end

    assign hz.stall       = w_stall;
    assign hz.pc_en       = ~w_stall;
    assign hz.ifid_en     = ~w_stall;
    assign hz.flush_ifid  = hz.flush & ~rst;
    assign hz.stall_count = r_stall_count;

    // The WB entry is the end of the scoreboard and feeds nothing further.
    assign w_unused = ^w_slot_q[SLOT_WB];

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_unit
// Brief    : Bench for hazard_stall_unit in three configurations driven in lockstep.
// Revision : 1.0
// ============================================================================
module tb_hazard_stall_unit;
    import pipeline_pkg::*;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       t_rst = 1'b1;
    logic [2:0] t_rs = 3'd0, t_rt = 3'd0, t_dst = 3'd0;
    logic       t_rs_used = 1'b0, t_rt_used = 1'b0, t_wr = 1'b0, t_flush = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // k=0: bypass, 16-bit count; k=1: no bypass, 16-bit; k=2: bypass, 4-bit count
    hazard_stall_unit_if #(.CNT_W(16)) if0 ();
    hazard_stall_unit_if #(.CNT_W(16)) if1 ();
    hazard_stall_unit_if #(.CNT_W(4))  if2 ();

    assign if0.id_rs = t_rs;  assign if0.id_rt = t_rt;  assign if0.id_dst = t_dst;
    assign if0.id_rs_used = t_rs_used;  assign if0.id_rt_used = t_rt_used;
    assign if0.id_reg_write = t_wr;  assign if0.flush = t_flush;
    assign if1.id_rs = t_rs;  assign if1.id_rt = t_rt;  assign if1.id_dst = t_dst;
    assign if1.id_rs_used = t_rs_used;  assign if1.id_rt_used = t_rt_used;
    assign if1.id_reg_write = t_wr;  assign if1.flush = t_flush;
    assign if2.id_rs = t_rs;  assign if2.id_rt = t_rt;  assign if2.id_dst = t_dst;
    assign if2.id_rs_used = t_rs_used;  assign if2.id_rt_used = t_rt_used;
    assign if2.id_reg_write = t_wr;  assign if2.flush = t_flush;

    hazard_stall_unit #(.WB_BYPASS(1), .CNT_W(16)) dut0 (.clk(clk), .rst(t_rst), .hz(if0));
    hazard_stall_unit #(.WB_BYPASS(0), .CNT_W(16)) dut1 (.clk(clk), .rst(t_rst), .hz(if1));
    hazard_stall_unit #(.WB_BYPASS(1), .CNT_W(4))  dut2 (.clk(clk), .rst(t_rst), .hz(if2));

    logic [2:0]  act_stall, act_pc, act_ifid, act_fl;
    logic [15:0] act_cnt [3];
    assign act_stall  = {if2.stall, if1.stall, if0.stall};
    assign act_pc     = {if2.pc_en, if1.pc_en, if0.pc_en};
    assign act_ifid   = {if2.ifid_en, if1.ifid_en, if0.ifid_en};
    assign act_fl     = {if2.flush_ifid, if1.flush_ifid, if0.flush_ifid};
    assign act_cnt[0] = if0.stall_count;
    assign act_cnt[1] = if1.stall_count;
    assign act_cnt[2] = {12'd0, if2.stall_count};

    // Reference: per config, the producers in flight by age (0 = one stage past ID).
    bit       m_v [3][3];
    bit [2:0] m_d [3][3];
    int       m_cnt   [3] = '{0, 0, 0};
    int       m_max   [3] = '{65535, 65535, 15};
    int       m_depth [3] = '{2, 3, 2};

    function automatic bit mdl_stall(int k);
        bit hit;
        hit = 1'b0;
        if (t_rst) return 1'b0;
        for (int s = 0; s < m_depth[k]; s++)
            if (m_v[k][s] && ((t_rs_used && m_d[k][s] == t_rs) || (t_rt_used && m_d[k][s] == t_rt)))
                hit = 1'b1;
        return hit && !t_flush;
    endfunction

    task automatic mdl_update();
        for (int k = 0; k < 3; k++) begin
            bit st;
            st = mdl_stall(k);
            if (t_rst) begin
                for (int s = 0; s < 3; s++) m_v[k][s] = 1'b0;
                m_cnt[k] = 0;
            end else begin
                for (int s = 2; s > 0; s--) begin
                    m_v[k][s] = m_v[k][s-1];
                    m_d[k][s] = m_d[k][s-1];
                end
                m_v[k][0] = t_wr && !t_flush && !st;
                m_d[k][0] = t_dst;
                if (st && m_cnt[k] < m_max[k]) m_cnt[k]++;
            end
        end
    endtask

    task automatic set_in(input logic r, input logic [2:0] rs, input logic rsu,
                          input logic [2:0] rt, input logic rtu,
                          input logic [2:0] dst, input logic wr, input logic fl);
        t_rst = r; t_rs = rs; t_rs_used = rsu; t_rt = rt; t_rt_used = rtu;
        t_dst = dst; t_wr = wr; t_flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        mdl_update();
        #1;
    endtask

    task automatic do_reset();
        set_in(1'b1, 3'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
               3'($urandom), 1'($urandom), 1'($urandom));
        tick();
        t_rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            set_in(1'b1, 3'($urandom), 1'b1, 3'($urandom), 1'b1, 3'($urandom), 1'b1, 1'b1);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if ({act_stall[k], act_pc[k], act_ifid[k], act_fl[k]} !== 4'b0110) begin
                    n_err++;
                    $display("FAIL reset k=%0d cyc=%0d {stall,pc_en,ifid_en,flush_ifid}=%b expected 0110",
                             k, c, {act_stall[k], act_pc[k], act_ifid[k], act_fl[k]});
                end
                n_vec++;
                if (act_cnt[k] !== 16'd0) begin
                    n_err++;
                    $display("FAIL reset_count k=%0d stall_count=%0d expected 0", k, act_cnt[k]);
                end
            end
            tick();
        end
        set_in(1'b0, 3'($urandom), 1'b1, 3'($urandom), 1'b1, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (act_stall[k] !== 1'b0) begin
                n_err++;
                $display("FAIL first_read k=%0d stall=%b expected 0", k, act_stall[k]);
            end
        end
        tick();
    endtask

    task automatic test_ex_dep();
        bit exp_st  [3][4] = '{'{1'b1, 1'b1, 1'b0, 1'b0},
                               '{1'b1, 1'b1, 1'b1, 1'b0},
                               '{1'b1, 1'b1, 1'b0, 1'b0}};
        int exp_cnt [3]    = '{2, 3, 2};
        do_reset();
        set_in(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if ({act_stall[k], act_pc[k], act_ifid[k]} !== {exp_st[k][c], ~exp_st[k][c], ~exp_st[k][c]}) begin
                    n_err++;
                    $display("FAIL ex_dep k=%0d cyc=%0d {stall,pc_en,ifid_en}=%b expected stall=%b",
                             k, c + 1, {act_stall[k], act_pc[k], act_ifid[k]}, exp_st[k][c]);
                end
            end
            tick();
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (act_cnt[k] !== 16'(exp_cnt[k])) begin
                n_err++;
                $display("FAIL ex_dep_count k=%0d stall_count=%0d expected %0d", k, act_cnt[k], exp_cnt[k]);
            end
        end
    endtask

    task automatic test_unused_operand();
        do_reset();
        // Reads and writes R5 itself: nothing in flight yet, so no self-hazard.
        set_in(1'b0, 3'd5, 1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (act_stall[k] !== 1'b0) begin
                    n_err++;
                    $display("FAIL unused_operand k=%0d cyc=%0d stall=%b expected 0", k, c, act_stall[k]);
                end
            end
            tick();
            set_in(1'b0, 3'd1, 1'b1, 3'd5, 1'b0, 3'd0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_flush();
        int exp_cnt [3] = '{1, 2, 1};
        do_reset();
        set_in(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if ({act_stall[k], act_pc[k], act_ifid[k], act_fl[k]} !== 4'b0111) begin
                n_err++;
                $display("FAIL flush_hazard k=%0d {stall,pc_en,ifid_en,flush_ifid}=%b expected 0111",
                         k, {act_stall[k], act_pc[k], act_ifid[k], act_fl[k]});
            end
        end
        tick();
        set_in(1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                bit exp;
                exp = (c == 0) || (k == 1);
                n_vec++;
                if ({act_stall[k], act_fl[k]} !== {exp, 1'b0}) begin
                    n_err++;
                    $display("FAIL after_flush k=%0d cyc=%0d {stall,flush_ifid}=%b expected %b0",
                             k, c, {act_stall[k], act_fl[k]}, exp);
                end
            end
            tick();
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (act_cnt[k] !== 16'(exp_cnt[k])) begin
                n_err++;
                $display("FAIL flush_count k=%0d stall_count=%0d expected %0d", k, act_cnt[k], exp_cnt[k]);
            end
        end
    endtask

    task automatic test_saturation();
        int exp_cnt  [3] = '{21, 24, 15};
        bit exp_rst  [3] = '{1'b0, 1'b0, 1'b0};
        do_reset();
        // Each instance reads and rewrites R6, so it keeps colliding with its predecessor.
        set_in(1'b0, 3'd6, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0);
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (act_stall[k] !== mdl_stall(k) || act_cnt[k] !== 16'(m_cnt[k])) begin
                    n_err++;
                    $display("FAIL saturate k=%0d cyc=%0d stall=%b count=%0d expected stall=%b count=%0d",
                             k, c, act_stall[k], act_cnt[k], mdl_stall(k), m_cnt[k]);
                end
            end
            tick();
        end
        t_rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if ({act_stall[k], act_cnt[k]} !== {exp_rst[k], 16'(exp_cnt[k])}) begin
                n_err++;
                $display("FAIL reset_mid_stall k=%0d stall=%b count=%0d expected stall=0 count=%0d",
                         k, act_stall[k], act_cnt[k], exp_cnt[k]);
            end
        end
        tick();
        t_rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if ({act_stall[k], act_cnt[k]} !== 17'd0) begin
                n_err++;
                $display("FAIL post_reset k=%0d stall=%b count=%0d expected stall=0 count=0",
                         k, act_stall[k], act_cnt[k]);
            end
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            set_in(($urandom_range(0, 63) == 0), 3'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
                   3'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                bit es, ef;
                es = mdl_stall(k);
                ef = t_flush && !t_rst;
                n_vec++;
                if ({act_stall[k], act_pc[k], act_ifid[k], act_fl[k]} !== {es, ~es, ~es, ef}) begin
                    n_err++;
                    $display("FAIL random_ctl k=%0d cyc=%0d {stall,pc_en,ifid_en,flush_ifid}=%b expected %b",
                             k, c, {act_stall[k], act_pc[k], act_ifid[k], act_fl[k]}, {es, ~es, ~es, ef});
                end
                n_vec++;
                if (act_cnt[k] !== 16'(m_cnt[k])) begin
                    n_err++;
                    $display("FAIL random_count k=%0d cyc=%0d stall_count=%0d expected %0d",
                             k, c, act_cnt[k], m_cnt[k]);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_ex_dep();
        test_unused_operand();
        test_flush();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
